// File: rtl/gray_ptr_sync_decoder.sv
// Purpose: synchronize a gray-coded pointer from the far clock domain, decode it to binary, and report per-cycle advance and illegal steps.
// Latency: a gray_in value shows on gray_sync SYNC_STAGES-1 edges after capture and on bin_out/upd/delta SYNC_STAGES edges after capture.
// Backpressure: none; the consumer must sample upd/delta in the cycle they are asserted.
module gray_ptr_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             upd,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic             ready
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    warm_cnt;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] gray_diff;
  logic             changed;
  logic             multi_bit;

  // Plain flop chain for the CDC crossing; nothing may sit between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < WIDTH; i++) bin_dec[i] = ^(gray_sync >> i);
  end

  // A step is illegal when more than one gray bit flips; x & (x-1) is nonzero exactly then.
  assign gray_diff = gray_sync ^ prev_gray;
  assign changed   = |gray_diff;
  assign multi_bit = |(gray_diff & (gray_diff - WIDTH'(1)));

  // Warm-up/run FSM with registered decode, change pulse, delta and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WARMUP;
      warm_cnt  <= '0;
      prev_gray <= '0;
      bin_out   <= '0;
      upd       <= 1'b0;
      delta     <= '0;
      step_err  <= 1'b0;
      ready     <= 1'b0;
    end else begin
      // Decode and history track in both states so RUN starts with no stale step.
      bin_out   <= bin_dec;
      prev_gray <= gray_sync;
      case (state)
        WARMUP: begin
          upd   <= 1'b0;
          delta <= '0;
          if (warm_cnt == CW'(SYNC_STAGES)) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + CW'(1);
          end
        end
        RUN: begin
          upd   <= changed;
          delta <= changed ? (bin_dec - bin_out) : '0;
          // A fresh error outranks a simultaneous clear.
          if (changed && multi_bit) step_err <= 1'b1;
          else if (err_clr)         step_err <= 1'b0;
        end
        default: state <= WARMUP;
      endcase
    end
  end

endmodule
